// File: rtl/sync_fifo_small.sv
// First-word-fall-through byte FIFO: synchronous storage array feeding a
// registered head-of-queue output, so the array itself can map to block RAM.
module sync_fifo_small #(
  parameter int A_WIDTH = 16,
  parameter int D_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] din,
  input  logic               wr_en,
  output logic               full,
  output logic [D_WIDTH-1:0] dout,
  input  logic               rd_en,
  output logic               empty
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] PTR_ONE = {{A_WIDTH{1'b0}}, 1'b1};

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [A_WIDTH:0]   wr_ptr;
  logic [A_WIDTH:0]   rd_ptr;
  logic               valid;
  logic               arr_empty;
  logic               wr_ok;
  logic               load;

  always_comb begin
    full      = (wr_ptr[A_WIDTH] != rd_ptr[A_WIDTH]) &&
                (wr_ptr[A_WIDTH-1:0] == rd_ptr[A_WIDTH-1:0]);
    arr_empty = (wr_ptr == rd_ptr);
    wr_ok     = wr_en && !full;
    // Refill the output register when it is empty or being popped this cycle.
    load      = !arr_empty && (!valid || rd_en);
    empty     = !valid;
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr[A_WIDTH-1:0]] <= din;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load) begin
        dout   <= mem[rd_ptr[A_WIDTH-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
        valid  <= 1'b1;
      end else if (rd_en && valid) begin
        valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_small.sv
// Directed scoreboard bench for sync_fifo_small: small (A_WIDTH=4) and
// full-size (A_WIDTH=16) instances sharing one clock.
module tb_sync_fifo_small;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;
  logic       full;
  logic       empty;
  logic [7:0] dout;

  logic [7:0] b_din;
  logic       b_wr_en;
  logic       b_rd_en;
  logic       b_full;
  logic       b_empty;
  logic [7:0] b_dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_v;

  always #5 CLK = ~CLK;

  sync_fifo_small #(.A_WIDTH(4), .D_WIDTH(8)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full),
    .dout(dout), .rd_en(rd_en), .empty(empty)
  );

  sync_fifo_small #(.A_WIDTH(16), .D_WIDTH(8)) u_big (
    .CLK(CLK), .rst_n(rst_n), .din(b_din), .wr_en(b_wr_en), .full(b_full),
    .dout(b_dout), .rd_en(b_rd_en), .empty(b_empty)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
    b_din = '0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    #3;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00)
      $display("FAIL reset_hold: empty=%b full=%b dout=%h, want 1 0 00", empty, full, dout);
    if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) n_fail++;
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
      $display("FAIL reset_release: empty=%b full=%b dout=%h, want 1 0 00", empty, full, dout);
      n_fail++;
    end
  endtask

  task automatic test_latency();
    din = 8'h61; wr_en = 1'b1; sb.push_back(8'h61);
    step();
    wr_en = 1'b0;
    n_checks++;
    if (empty !== 1'b1) begin
      $display("FAIL latency_edge_n: empty=%b, want 1", empty); n_fail++;
    end
    step();
    n_checks++;
    exp_v = sb.pop_front();
    if (empty !== 1'b0 || dout !== exp_v) begin
      $display("FAIL latency_edge_n1: empty=%b dout=%h, want 0 %h", empty, dout, exp_v);
      n_fail++;
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (empty !== 1'b1) begin
      $display("FAIL latency_pop: empty=%b, want 1", empty); n_fail++;
    end
  endtask

  // 16 array words plus the output register hold 17 words before full rises.
  task automatic test_fill_full();
    int budget;
    for (int i = 0; i < 17; i++) begin
      din = 8'(i); wr_en = 1'b1; sb.push_back(8'(i));
      step();
      n_checks++;
      if (full !== (i == 16)) begin
        $display("FAIL fill_full[%0d]: full=%b, want %b", i, full, (i == 16)); n_fail++;
      end
    end
    // Write while full together with a pop: the write must still be dropped.
    din = 8'h11; wr_en = 1'b1;
    budget = 100;
    while (sb.size() != 0 && budget > 0) begin
      if (!empty) begin
        exp_v = sb.pop_front();
        n_checks++;
        if (dout !== exp_v) begin
          $display("FAIL fill_read: dout=%h, want %h", dout, exp_v); n_fail++;
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      step();
      wr_en = 1'b0;
      budget--;
    end
    rd_en = 1'b0;
    n_checks++;
    if (sb.size() != 0 || empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL fill_drain_end: left=%0d empty=%b full=%b, want 0 1 0", sb.size(), empty, full);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int budget;
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (full !== 1'b0) begin
        $display("FAIL stream_full[%0d]: full=%b, want 0", i, full); n_fail++;
      end
      if (!empty) begin
        exp_v = sb.pop_front();
        n_checks++;
        if (dout !== exp_v) begin
          $display("FAIL stream_data: dout=%h, want %h", dout, exp_v); n_fail++;
        end
      end
      din = 8'(i); wr_en = 1'b1; sb.push_back(8'(i));
      step();
    end
    wr_en = 1'b0;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      if (!empty) begin
        exp_v = sb.pop_front();
        n_checks++;
        if (dout !== exp_v) begin
          $display("FAIL stream_tail: dout=%h, want %h", dout, exp_v); n_fail++;
        end
      end
      step();
      budget--;
    end
    rd_en = 1'b0;
    n_checks++;
    if (sb.size() != 0 || empty !== 1'b1) begin
      $display("FAIL stream_end: left=%0d empty=%b, want 0 1", sb.size(), empty); n_fail++;
    end
  endtask

  task automatic test_underflow();
    int budget;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (empty !== 1'b1 || full !== 1'b0) begin
        $display("FAIL underflow_idle: empty=%b full=%b, want 1 0", empty, full); n_fail++;
      end
    end
    rd_en = 1'b0;
    din = 8'h5A; wr_en = 1'b1; sb.push_back(8'h5A);
    step();
    wr_en = 1'b0;
    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      if (!empty) begin
        exp_v = sb.pop_front();
        n_checks++;
        if (dout !== exp_v) begin
          $display("FAIL underflow_read: dout=%h, want %h", dout, exp_v); n_fail++;
        end
        rd_en = 1'b1;
      end
      step();
      budget--;
    end
    rd_en = 1'b0;
    n_checks++;
    if (sb.size() != 0 || empty !== 1'b1) begin
      $display("FAIL underflow_end: left=%0d empty=%b, want 0 1", sb.size(), empty); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    for (int i = 0; i < 5; i++) begin
      din = 8'hC0 + 8'(i); wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
      $display("FAIL reset_mid: empty=%b full=%b dout=%h, want 1 0 00", empty, full, dout);
      n_fail++;
    end
    step();
    rst_n = 1'b1;
    sb.delete();
    din = 8'hAB; wr_en = 1'b1; sb.push_back(8'hAB);
    step();
    wr_en = 1'b0;
    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      if (!empty) begin
        exp_v = sb.pop_front();
        n_checks++;
        if (dout !== exp_v) begin
          $display("FAIL reset_mid_read: dout=%h, want %h", dout, exp_v); n_fail++;
        end
        rd_en = 1'b1;
      end
      step();
      budget--;
    end
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (empty !== 1'b1 || sb.size() != 0) begin
        $display("FAIL reset_mid_stale: empty=%b left=%0d dout=%h, want 1 0", empty, sb.size(), dout);
        n_fail++;
      end
      step();
    end
  endtask

  task automatic test_wide_abc();
    int budget;
    logic [7:0] msg [3];
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    for (int i = 0; i < 3; i++) begin
      b_din = msg[i]; b_wr_en = 1'b1; sb.push_back(msg[i]);
      step();
      n_checks++;
      if (b_full !== 1'b0) begin
        $display("FAIL wide_full: full=%b, want 0", b_full); n_fail++;
      end
    end
    b_wr_en = 1'b0;
    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      if (!b_empty) begin
        exp_v = sb.pop_front();
        n_checks++;
        if (b_dout !== exp_v) begin
          $display("FAIL wide_read: dout=%h, want %h", b_dout, exp_v); n_fail++;
        end
        b_rd_en = 1'b1;
      end else begin
        b_rd_en = 1'b0;
      end
      step();
      budget--;
    end
    b_rd_en = 1'b0;
    n_checks++;
    if (sb.size() != 0 || b_empty !== 1'b1 || b_full !== 1'b0) begin
      $display("FAIL wide_end: left=%0d empty=%b full=%b, want 0 1 0", sb.size(), b_empty, b_full);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_full();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_wide_abc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
